// File: rtl/delay_pipe_ctrl_if.sv
// Handshake bundle between the layer feeder, the delay-pipe flow controller and the
// downstream MAC stage. The controller takes the slave side.
interface delay_pipe_ctrl_if #(
    parameter int Depth   = 4,
    parameter int CntBits = 16
);
    localparam int OccW = $clog2(Depth + 1);

    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               en;
    logic               flush;
    logic               flush_done;
    logic               busy;
    logic [OccW-1:0]    occupancy;
    logic               stall_clr;
    logic [CntBits-1:0] stall_cnt;

    modport master (
        output in_valid, out_ready, flush, stall_clr,
        input  in_ready, out_valid, en, flush_done, busy, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, out_ready, flush, stall_clr,
        output in_ready, out_valid, en, flush_done, busy, occupancy, stall_cnt
    );
endinterface

// File: rtl/delay_pipe_ctrl.sv
// Flow controller for an enable-gated delay line: derives the shared shift enable from
// upstream/downstream handshakes, tracks per-stage valid bits, drains on flush, counts stalls.
//
// state | meaning
// IDLE  | pipeline empty, waiting for a word
// RUN   | at least one word in flight, accepting input
// FLUSH | input blocked, shifting bubbles until the pipeline is empty
module delay_pipe_ctrl #(
    parameter int Depth   = 4,
    parameter int CntBits = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    delay_pipe_ctrl_if.slave        bus
);
    localparam int OccW = $clog2(Depth + 1);
    localparam logic [OccW-1:0]    OccOne = OccW'(1);
    localparam logic [CntBits-1:0] CntOne = CntBits'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [Depth-1:0]   vld;
    logic [OccW-1:0]    occ;
    logic [OccW-1:0]    occ_nxt;
    logic [CntBits-1:0] stall_cnt;
    logic               any_vld;
    logic               adv;
    logic               in_ready;
    logic               en;
    logic               in_fire;
    logic               out_fire;
    logic               flush_done;

    // The head may move when it is empty or downstream takes it; one enable drives all stages.
    always_comb begin
        any_vld  = |vld;
        adv      = ~vld[Depth-1] | bus.out_ready;
        in_ready = 1'b0;
        en       = 1'b0;
        if (state == FLUSH) begin
            en = adv & any_vld;
        end else begin
            in_ready = adv;
            en       = adv & (bus.in_valid | any_vld);
        end
        in_fire  = bus.in_valid & in_ready;
        out_fire = vld[Depth-1] & bus.out_ready;
    end

    always_comb begin
        occ_nxt = occ;
        case ({in_fire, out_fire})
            2'b10:   occ_nxt = occ + OccOne;
            2'b01:   occ_nxt = occ - OccOne;
            default: occ_nxt = occ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush)   state_nxt = FLUSH;
                else if (in_fire) state_nxt = RUN;
            end
            RUN: begin
                if (bus.flush)           state_nxt = FLUSH;
                else if (occ_nxt == '0)  state_nxt = IDLE;
            end
            FLUSH: begin
                if (occ == '0) begin
                    state_nxt  = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            occ   <= '0;
        end else begin
            state <= state_nxt;
            occ   <= occ_nxt;
        end
    end

    generate
        if (Depth == 1) begin : g_single
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)   vld <= '0;
                else if (en) vld <= in_fire;
            end
        end else begin : g_multi
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)   vld <= '0;
                else if (en) vld <= {vld[Depth-2:0], in_fire};
            end
        end
    endgenerate

    // Clear has priority over counting; the counter sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (bus.stall_clr) begin
            stall_cnt <= '0;
        end else if (vld[Depth-1] & ~bus.out_ready & ~(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CntOne;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld[Depth-1];
    assign bus.en         = en;
    assign bus.flush_done = flush_done;
    assign bus.busy       = (state != IDLE);
    assign bus.occupancy  = occ;
    assign bus.stall_cnt  = stall_cnt;
endmodule
